// File: rtl/can_rx_drain_pkg.sv
// Shared definitions for the CAN receive-buffer drain engine: controller
// register map, interrupt-register bit positions, command codes, FSM encoding.
package can_rx_drain_pkg;

    localparam int WB_ADR_W = 8;
    localparam int WB_DAT_W = 8;

    // Controller register addresses (PeliCAN mode)
    localparam logic [7:0] ADR_CMD      = 8'd1;
    localparam logic [7:0] ADR_IR       = 8'd3;
    localparam logic [7:0] ADR_INFO     = 8'd16;
    localparam logic [7:0] ADR_ID       = 8'd17;
    localparam logic [7:0] ADR_STD_DATA = 8'd19;
    localparam logic [7:0] ADR_EXT_DATA = 8'd21;

    // Interrupt register bits
    localparam int IR_RI = 0;   // receive buffer holds a frame
    localparam int IR_TI = 1;   // transmission complete
    localparam logic [7:0] IR_ERR_MASK = 8'hFC;

    // Command register: release receive buffer
    localparam logic [7:0] CMD_RRB = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        RD_IR,
        RD_INFO,
        RD_ID,
        RD_DATA,
        WR_CMD,
        PRESENT,
        FAULT
    } state_t;

    // Number of data bytes actually stored in the receive buffer
    function automatic logic [3:0] data_len(input logic rtr, input logic [3:0] dlc);
        if (rtr)
            return 4'd0;
        else if (dlc > 4'd8)
            return 4'd8;
        else
            return dlc;
    endfunction

endpackage

// File: rtl/can_wb_master_port.sv
// Single-access Wishbone master: launches one read or write on req, reports
// completion (done/rdata, combinational on the ack clock) or an ack timeout.
module can_wb_master_port
    import can_rx_drain_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                req,
    input  logic                we,
    input  logic [WB_ADR_W-1:0] adr,
    input  logic [WB_DAT_W-1:0] dat,
    output logic                done,
    output logic [WB_DAT_W-1:0] rdata,
    output logic                timeout,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    input  logic                wb_ack_i
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;
    logic          expired;

    // Last clock of the wait window: stb has been high ACK_TIMEOUT clocks here
    assign expired = (wait_cnt == CW'(ACK_TIMEOUT - 1));
    assign done    = wb_stb_o & wb_ack_i;
    assign timeout = wb_stb_o & ~wb_ack_i & expired;
    assign rdata   = wb_dat_i;

    // Bus cycle control: raise on req when idle, drop on ack or timeout
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wait_cnt <= '0;
        end else if (wb_stb_o) begin
            if (wb_ack_i || expired) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end else if (req) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/can_rx_drain.sv
// Drains received frames from a PeliCAN-mode CAN controller over Wishbone:
// reads IR, frame info, ID and data, releases the buffer, then presents the
// frame on a valid/ready interface.
module can_rx_drain
    import can_rx_drain_pkg::*;
#(
    parameter int ACK_TIMEOUT   = 255,
    parameter int EXTENDED_MODE = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        enable,
    input  logic        irq_n,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_ext,
    output logic        frame_rtr,
    output logic [3:0]  frame_dlc,
    output logic [28:0] frame_id,
    output logic [63:0] frame_data,
    output logic        tx_done,
    output logic [7:0]  err_irq,
    output logic        bus_error
);

    // Only PeliCAN register layout is implemented; other modes never start
    localparam bit MODE_OK = (EXTENDED_MODE == 1);

    state_t     state, state_nx;
    logic [2:0] idx;
    logic [3:0] n_data;
    logic       id_last, data_last;
    logic       req, acc_we;
    logic [7:0] acc_adr, acc_dat;
    logic       done, timeout;
    logic [7:0] rdata;

    can_wb_master_port #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_port (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .req        (req),
        .we         (acc_we),
        .adr        (acc_adr),
        .dat        (acc_dat),
        .done       (done),
        .rdata      (rdata),
        .timeout    (timeout),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    assign frame_valid = (state == PRESENT);
    assign n_data      = data_len(frame_rtr, frame_dlc);
    assign id_last     = frame_ext ? (idx == 3'd3) : (idx == 3'd1);
    assign data_last   = ({1'b0, idx} == (n_data - 4'd1));

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and current bus request
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = ADR_IR;
        acc_dat  = 8'h00;
        case (state)
            IDLE: begin
                if (MODE_OK && enable && !irq_n && !frame_valid && !bus_error)
                    state_nx = RD_IR;
            end
            RD_IR: begin
                req     = 1'b1;
                acc_adr = ADR_IR;
                if (done)
                    state_nx = rdata[IR_RI] ? RD_INFO : IDLE;
            end
            RD_INFO: begin
                req     = 1'b1;
                acc_adr = ADR_INFO;
                if (done)
                    state_nx = RD_ID;
            end
            RD_ID: begin
                req     = 1'b1;
                acc_adr = ADR_ID + {5'd0, idx};
                if (done && id_last)
                    state_nx = (n_data == 4'd0) ? WR_CMD : RD_DATA;
            end
            RD_DATA: begin
                req     = 1'b1;
                acc_adr = (frame_ext ? ADR_EXT_DATA : ADR_STD_DATA) + {5'd0, idx};
                if (done && data_last)
                    state_nx = WR_CMD;
            end
            WR_CMD: begin
                req     = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMD;
                acc_dat = CMD_RRB;
                if (done)
                    state_nx = PRESENT;
            end
            PRESENT: begin
                if (frame_ready)
                    state_nx = IDLE;
            end
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
        if (timeout)
            state_nx = FAULT;
    end

    // Frame assembly, status capture and byte index
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            idx        <= 3'd0;
            frame_ext  <= 1'b0;
            frame_rtr  <= 1'b0;
            frame_dlc  <= 4'd0;
            frame_id   <= '0;
            frame_data <= '0;
            tx_done    <= 1'b0;
            err_irq    <= 8'h00;
            bus_error  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (timeout)
                bus_error <= 1'b1;
            if (done) begin
                case (state)
                    RD_IR: begin
                        err_irq <= rdata & IR_ERR_MASK;
                        tx_done <= rdata[IR_TI];
                        if (rdata[IR_RI]) begin
                            frame_ext  <= 1'b0;
                            frame_rtr  <= 1'b0;
                            frame_dlc  <= 4'd0;
                            frame_id   <= '0;
                            frame_data <= '0;
                            idx        <= 3'd0;
                        end
                    end
                    RD_INFO: begin
                        frame_ext <= rdata[7];
                        frame_rtr <= rdata[6];
                        frame_dlc <= rdata[3:0];
                        idx       <= 3'd0;
                    end
                    RD_ID: begin
                        if (frame_ext) begin
                            case (idx)
                                3'd0:    frame_id[28:21] <= rdata;
                                3'd1:    frame_id[20:13] <= rdata;
                                3'd2:    frame_id[12:5]  <= rdata;
                                default: frame_id[4:0]   <= rdata[7:3];
                            endcase
                        end else begin
                            if (idx == 3'd0)
                                frame_id[10:3] <= rdata;
                            else
                                frame_id[2:0]  <= rdata[7:5];
                        end
                        idx <= id_last ? 3'd0 : idx + 3'd1;
                    end
                    RD_DATA: begin
                        // byte 0 lands in the top byte: bit offset = (7 - idx) * 8
                        frame_data[{~idx, 3'b000} +: 8] <= rdata;
                        idx <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/can_rx_drain.md
CAN_RX_DRAIN -- requirements
Module: can_rx_drain

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: maximum clocks to wait for wb_ack_i per access.
REQ-002 SHALL have parameter EXTENDED_MODE, default 1: controller runs in PeliCAN mode (1); only 1 is supported.
REQ-003 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-004 wb_rst_n_i  in  1  reset; synchronous, active-low.
REQ-005 enable  in  1  when 0, starts no new drain sequence.
REQ-006 irq_n  in  1  controller interrupt output, active-low.
REQ-007 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master cycle, strobe and write-enable.
REQ-008 wb_adr_o  out  8  controller register address.
REQ-009 wb_dat_o  out  8  write data.
REQ-010 wb_dat_i  in  8  read data.
REQ-011 wb_ack_i  in  1  access acknowledge.
REQ-012 frame_valid  out  1  received frame available.
REQ-013 frame_ready  in  1  consumer accepts the frame.
REQ-014 frame_ext, frame_rtr  out  1 each  extended-ID flag and RTR flag.
REQ-015 frame_dlc  out  4  raw DLC.
REQ-016 frame_id  out  29  ID, right-aligned (standard IDs in [10:0]).
REQ-017 frame_data  out  64  data bytes; byte 0 in [63:56]; unused bytes are 0.
REQ-018 tx_done  out  1  one-clock pulse when the read IR has bit1 (TX complete) set.
REQ-019 err_irq  out  8  IR value with bits 1:0 masked; updated on every IR read.
REQ-020 bus_error  out  1  sticky flag, set on ack timeout.

Function
REQ-021 SHALL use states IDLE, RD_IR, RD_INFO, RD_ID, RD_DATA, WR_CMD, PRESENT, FAULT.
REQ-022 IDLE -> RD_IR when enable=1, irq_n=0, frame_valid=0 and bus_error=0.
REQ-023 Each access: assert cyc, stb and adr (and we/dat for writes) together; hold until the ack clock; deassert the next clock; one access outstanding; capture read data on the ack clock.
REQ-024 RD_IR reads address 3.
  - bit0 set -> RD_INFO.
  - bit0 clear -> IDLE.
  - tx_done pulses on the clock after the ack if bit1 is set.
REQ-025 RD_INFO reads address 16: frame_ext=bit7, frame_rtr=bit6, frame_dlc=bits3:0.
REQ-026 RD_ID, extended frame: read addresses 17..20.
  - id[28:21]=b17, id[20:13]=b18, id[12:5]=b19, id[4:0]=b20[7:3].
REQ-027 RD_ID, standard frame: read addresses 17..18.
  - id[10:3]=b17, id[2:0]=b18[7:5], id[28:11]=0.
REQ-028 RD_DATA reads N=min(dlc,8) bytes from address 21 (extended) or 19 (standard), incrementing.
  - N=0 when RTR=1 or dlc=0; the state is skipped.
REQ-029 WR_CMD writes 0x04 (release receive buffer) to address 1, then -> PRESENT.
REQ-030 PRESENT asserts frame_valid; all frame_* outputs are stable while valid=1.
  - valid=1 and ready=1 on the same clock -> valid=0 on the next clock, -> IDLE.
REQ-031 More frames in the controller FIFO are drained by the IR re-read on the next IDLE pass; irq_n is not edge-detected.
REQ-032 Ack timeout:
  - wb_ack_i absent for ACK_TIMEOUT clocks after stb rises -> drop cyc/stb, set bus_error, -> FAULT.
  - FAULT is left only by reset.
REQ-033 enable=0 mid-sequence does not abort; the sequence completes through PRESENT.
REQ-034 Latency: irq_n low to frame_valid = sum of access latencies (each ack delay + 1) + 1 clock.

Reset
REQ-035 wb_rst_n_i=0 at a clock edge -> state IDLE, all outputs 0, frame registers cleared, timeout counter 0, bus_error 0.
REQ-036 Reset mid-access drops cyc/stb on the same edge; the partial frame is discarded.

Structure
REQ-037 A shared package holds:
  - register addresses (IR=3, CMD=1, INFO=16, ID=17, EXT_DATA=21, STD_DATA=19);
  - IR bit indices;
  - CMD_RRB=0x04;
  - the state encoding.
REQ-038 Sub-module can_wb_master_port SHALL implement one Wishbone access with timeout (req/we/adr/dat in; done/rdata/timeout out).

Verification
REQ-039 Ext frame: ID 0x0123457, DLC 8, data 0xdeadbeefbadc0fff -> frame_valid with frame_ext=1, frame_id=0x0123457, frame_data=0xdeadbeefbadc0fff; exactly one write of 0x04 to address 1.
REQ-040 Std RTR frame: ID 0x5A3, DLC 4 -> frame_id=0x5A3, frame_rtr=1, frame_data=0; no reads of addresses 19..26.
REQ-041 DLC=15 frame -> exactly 8 data reads at addresses 21..28; frame_dlc=15.
REQ-042 IR=0x02 -> tx_done pulses once; no RD_INFO access; returns to IDLE.
REQ-043 Two frames queued, frame_ready held 0 for 50 clocks -> no IR read while valid=1; second frame presented after the first handshake.
REQ-044 Ack withheld -> cyc drops after 255 clocks, bus_error=1; FAULT until reset.
